obb_iter_ctrl: RTL

OBB_ITER_CTRL -- requirements
Module: obb_iter_ctrl

---
 rtl/obb_pkg.sv | 26 ++
 rtl/obb_wait_timer.sv | 41 ++++
 rtl/obb_iter_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/obb_pkg.sv
// Shared definitions for the OBB diagonalisation blocks: controller state
// codes, the identity scale used when the matrix mux seeds a run, and the
// matrix element width.
package obb_pkg;

   localparam int DATA_W = 21;
   localparam logic [DATA_W-1:0] IDENT_SCALE = 21'd100;

   // The codes are visible outside the controller (matrix mux, rotation
   // datapath), so they are fixed values rather than tool-chosen encodings.
   typedef enum logic [3:0] {
      ST_IDLE  = 4'b0000,
      ST_PIVOT = 4'b0010,
      ST_ROT   = 4'b0011,
      ST_CHECK = 4'b0100,
      ST_LOAD  = 4'b1001,
      ST_DONE  = 4'b1111
   } obb_state_e;

   // The matrix mux loads the scaled identity only in LOAD of the first sweep.
   function automatic logic load_identity(input obb_state_e st,
                                          input logic [2:0] iter);
      return (st == ST_LOAD) && (iter == 3'd0);
   endfunction

endpackage

// File: rtl/obb_wait_timer.sv
// Cycle counter guarding the ROT wait. clear zeroes it, enable counts one
// cycle, and expired flags the counting cycle in which the count reaches limit.
module obb_wait_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] limit,
   output logic             expired
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W:0]   cnt_inc;

   // One extra bit so limit = all-ones compares without overflow.
   assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
   assign expired = enable && (cnt_inc == {1'b0, limit});

   // Next count: clear wins over enable.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = cnt_inc[CNT_W-1:0];
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/obb_iter_ctrl.sv
// Jacobi sweep controller for the OBB eigen-solver. Sequences
// LOAD -> PIVOT -> ROT -> CHECK per sweep, stops on convergence, on the
// last allowed sweep, or on a rotation timeout.
//
// Handshake: start is a one-cycle request honoured only in IDLE (ignored
// while busy, including the DONE cycle, and never queued); done is a
// one-cycle completion pulse; rot_done is honoured only in ROT and conv
// only in CHECK.
module obb_iter_ctrl
   import obb_pkg::*;
#(
   parameter int MAX_ITER    = 5,
   parameter int ROT_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       conv,
   input  logic       rot_done,
   output logic [3:0] state,
   output logic [2:0] iteration_cnt,
   output logic       busy,
   output logic       done,
   output logic       timeout_err
);

   localparam logic [2:0] LAST_ITER = 3'(MAX_ITER - 1);
   localparam logic [7:0] ROT_LIMIT = 8'(ROT_TIMEOUT);

   logic       rst_meta_q;
   logic       rst_sync_q;
   obb_state_e state_q, state_d;
   logic [2:0] iter_q, iter_d;
   logic       terr_q, terr_d;
   logic       tmr_clear;
   logic       tmr_en;
   logic       tmr_expired;

   // Reset synchroniser: asserts immediately, releases two edges later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_meta_q <= 1'b0;
         rst_sync_q <= 1'b0;
      end else begin
         rst_meta_q <= 1'b1;
         rst_sync_q <= rst_meta_q;
      end
   end

   // The wait counter is zeroed in PIVOT so every ROT starts from zero.
   assign tmr_clear = (state_q == ST_PIVOT);
   assign tmr_en    = (state_q == ST_ROT) && !rot_done;

   obb_wait_timer #(
      .CNT_W (8)
   ) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_sync_q),
      .clear   (tmr_clear),
      .enable  (tmr_en),
      .limit   (ROT_LIMIT),
      .expired (tmr_expired)
   );

   // Next-state, sweep index and sticky timeout flag.
   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      terr_d  = terr_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD;
               iter_d  = 3'd0;
               terr_d  = 1'b0;
            end
         end
         ST_LOAD:  state_d = ST_PIVOT;
         ST_PIVOT: state_d = ST_ROT;
         ST_ROT: begin
            // rot_done beats a timeout landing in the same cycle.
            if (rot_done) begin
               state_d = ST_CHECK;
            end else if (tmr_expired) begin
               state_d = ST_DONE;
               terr_d  = 1'b1;
            end
         end
         ST_CHECK: begin
            if (conv || (iter_q == LAST_ITER)) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_LOAD;
               iter_d  = iter_q + 3'd1;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Controller registers.
   always_ff @(posedge clk or negedge rst_sync_q) begin
      if (!rst_sync_q) begin
         state_q <= ST_IDLE;
         iter_q  <= 3'd0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
         terr_q  <= terr_d;
      end
   end

   assign state         = state_q;
   assign iteration_cnt = iter_q;
   assign busy          = (state_q != ST_IDLE);
   assign done          = (state_q == ST_DONE);
   assign timeout_err   = terr_q;

endmodule
